ysyx_24120013_mp_regfile: RTL and testbench
===========================================

YSYX_24120013_MP_REGFILE -- requirements
Module: ysyx_24120013_mp_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_RD, default 2, read port count (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports wen0/wen1  input  1 each  write enables; port 1 has priority.
REQ-007 SHALL have ports waddr0/waddr1  input  ADDR_WIDTH each  write indices.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_WIDTH each  write data.
REQ-009 SHALL have port ren  input  NUM_RD  per-port read enable.
REQ-010 SHALL have port raddr  input  NUM_RD*ADDR_WIDTH  packed read indices; port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port rdata  output  NUM_RD*DATA_WIDTH  packed registered read data.
REQ-012 SHALL have port rbusy  output  NUM_RD  registered scoreboard busy flag per read port.
REQ-013 SHALL have ports iss_en/iss_addr  input  1/ADDR_WIDTH  mark destination register pending.

Function
REQ-014 SHALL write wdataN to entry waddrN on a rising edge when wenN=1.
REQ-015 SHALL, when both write ports target the same index in one cycle, store wdata1.
REQ-016 SHALL discard writes to index 0; entry 0 always reads 0.
REQ-017 SHALL update rdata slice k one cycle after an edge where ren[k]=1, with entry raddr[k] value.
REQ-018 SHALL hold rdata slice k and rbusy[k] unchanged while ren[k]=0.
REQ-019 SHALL keep one busy bit per entry; iss_en=1 sets busy[iss_addr] at the edge.
REQ-020 SHALL clear busy[waddrN] at the edge where wenN=1.
REQ-021 SHALL, on simultaneous issue and write to the same index, leave busy set (issue wins).
REQ-022 SHALL ignore issue to index 0; busy[0] is constant 0.
REQ-023 SHALL sample rbusy[k] with the same ren[k] as rdata; its value follows the read-vs-write ordering of REQ-028/029.
REQ-024 SHALL give every read port independent access; any mix of identical or distinct raddr is legal.

Reset
REQ-025 SHALL, while rst=0, asynchronously clear all entries, all busy bits, rdata and rbusy to 0.
REQ-026 SHALL ignore writes, issues and reads on the edge on which rst deasserts; normal operation resumes on the following edge.
REQ-027 SHALL abort any pending scoreboard state on reset mid-operation; no write is replayed.

Configuration
REQ-028 SHALL, with YSYX_24120013_RF_BYPASS_EN defined, return same-edge write data (wdata1 over wdata0) on a read whose raddr equals an active waddr (nonzero), and report busy cleared unless re-issued that edge.
REQ-029 SHALL, without YSYX_24120013_RF_BYPASS_EN, return the pre-write entry value and pre-edge busy state on such a same-edge collision (read-first).

Verification
REQ-030 SHALL cover: reset, wen0=1 waddr0=5 wdata0=0x1234, next edge ren=01 raddr0=5 -> rdata slice0=0x00001234 after one cycle.
REQ-031 SHALL cover: wen0=wen1=1, both waddr=7, wdata0=0xAAAA, wdata1=0x5555 -> later read of 7 returns 0x5555.
REQ-032 SHALL cover: wen0=1 waddr0=0 wdata0=0xFFFFFFFF; iss_en=1 iss_addr=0 -> read of 0 gives 0, rbusy=0.
REQ-033 SHALL cover: iss 9; read 9 -> rbusy=1; wen1=1 waddr1=9 wdata1=0x77; read 9 -> rbusy=0, rdata=0x77; iss 9 and write 9 same edge -> rbusy=1.
REQ-034 SHALL cover: reg 3=0x10, same edge wen0=1 waddr0=3 wdata0=0x20 and read 3 -> rdata=0x20 with BYPASS_EN, 0x10 without.
REQ-035 SHALL cover: entries 1..4 written, iss 2, rst pulsed low mid-cycle -> rdata, rbusy cleared immediately; all reads of 1..4 return 0.

Source files
------------

// File: rtl/ysyx_24120013_mp_regfile.sv
// Multi-port register file: 2 write ports, NUM_RD registered read ports, per-entry busy scoreboard.
// Latency: 1 cycle from read enable to rdata/rbusy; writes and issues take effect at the edge.
// Backpressure: none, every port is accepted each cycle. Optional macro YSYX_24120013_RF_BYPASS_EN forwards same-edge writes to reads.
module ysyx_24120013_mp_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wen0,
    input  logic                           wen1,
    input  logic [ADDR_WIDTH-1:0]          waddr0,
    input  logic [ADDR_WIDTH-1:0]          waddr1,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic [NUM_RD-1:0]              ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_RD-1:0]              rbusy,
    input  logic                           iss_en,
    input  logic [ADDR_WIDTH-1:0]          iss_addr
);

    localparam int NUM_ENT = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]        mem_q [NUM_ENT];
    logic [DATA_WIDTH-1:0]        mem_d [NUM_ENT];
    logic [NUM_ENT-1:0]           busy_q, busy_d;
    // Low through the first edge after reset release so that edge is ignored.
    logic                         run_q;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_RD-1:0]            rbusy_q, rbusy_d;

    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [DATA_WIDTH-1:0]        rd_val;
    logic                         rd_busy;

    assign rdata = rdata_q;
    assign rbusy = rbusy_q;

    // Next entry/busy state: port 1 beats port 0, an issue beats a write-clear, entry 0 is never touched.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            mem_d[i] = mem_q[i];
        end
        busy_d = busy_q;
        if (run_q) begin
            for (int i = 1; i < NUM_ENT; i++) begin
                if (wen1 && (waddr1 == ADDR_WIDTH'(i))) begin
                    mem_d[i] = wdata1;
                end else if (wen0 && (waddr0 == ADDR_WIDTH'(i))) begin
                    mem_d[i] = wdata0;
                end
                if (iss_en && (iss_addr == ADDR_WIDTH'(i))) begin
                    busy_d[i] = 1'b1;
                end else if ((wen1 && (waddr1 == ADDR_WIDTH'(i))) ||
                             (wen0 && (waddr0 == ADDR_WIDTH'(i)))) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    // Read data/busy capture per port; disabled ports hold their last value.
    always_comb begin
        rdata_d = rdata_q;
        rbusy_d = rbusy_q;
        rd_addr = '0;
        rd_val  = '0;
        rd_busy = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (run_q && ren[k]) begin
                rd_addr = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
                rd_val  = mem_q[rd_addr];
                rd_busy = busy_q[rd_addr];
`ifdef YSYX_24120013_RF_BYPASS_EN
                // Forward the write landing on this edge; busy reads as cleared unless re-issued now.
                if (rd_addr != '0) begin
                    if (wen1 && (waddr1 == rd_addr)) begin
                        rd_val  = wdata1;
                        rd_busy = iss_en && (iss_addr == rd_addr);
                    end else if (wen0 && (waddr0 == rd_addr)) begin
                        rd_val  = wdata0;
                        rd_busy = iss_en && (iss_addr == rd_addr);
                    end
                end
`endif
                rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_val;
                rbusy_d[k]                          = rd_busy;
            end
        end
    end

    // State registers with asynchronous clear; reset also drops any pending scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= 1'b0;
            busy_q  <= '0;
            rdata_q <= '0;
            rbusy_q <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            run_q   <= 1'b1;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
            for (int i = 0; i < NUM_ENT; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24120013_mp_regfile.sv
module tb_ysyx_24120013_mp_regfile;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NE = 1 << AW;

    logic             clk;
    logic             rst;
    logic             wen0, wen1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR-1:0]    ren;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural register contents and pending flags.
    logic [DW-1:0] m [NE];
    logic          b [NE];
    logic [DW-1:0] exp_rd [NR];
    logic          exp_rb [NR];
    logic          mrun;

    ysyx_24120013_mp_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst),
        .wen0(wen0), .wen1(wen1),
        .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ren(ren), .raddr(raddr),
        .rdata(rdata), .rbusy(rbusy),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m[i] = '0;
            b[i] = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
            exp_rd[k] = '0;
            exp_rb[k] = 1'b0;
        end
        mrun = 1'b0;
    endtask

    // Applies one clock edge worth of architectural rules to the model.
    task automatic model_edge();
        logic [AW-1:0] a;
        logic          hit0, hit1;
        if (!mrun) begin
            mrun = 1'b1;
            return;
        end
        for (int k = 0; k < NR; k++) begin
            if (ren[k]) begin
                a = raddr[k*AW +: AW];
                exp_rd[k] = m[a];
                exp_rb[k] = b[a];
`ifdef YSYX_24120013_RF_BYPASS_EN
                hit0 = wen0 && (waddr0 == a);
                hit1 = wen1 && (waddr1 == a);
                if (a != 0 && (hit0 || hit1)) begin
                    exp_rd[k] = hit1 ? wdata1 : wdata0;
                    exp_rb[k] = iss_en && (iss_addr == a);
                end
`else
                hit0 = 1'b0;
                hit1 = 1'b0;
`endif
            end
        end
        if (wen0 && waddr0 != 0) m[waddr0] = wdata0;
        if (wen1 && waddr1 != 0) m[waddr1] = wdata1;
        if (wen0) b[waddr0] = 1'b0;
        if (wen1) b[waddr1] = 1'b0;
        if (iss_en && iss_addr != 0) b[iss_addr] = 1'b1;
        b[0] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s rdata[%0d]", tag, k), rdata[k*DW +: DW], exp_rd[k]);
            chk($sformatf("%s rbusy[%0d]", tag, k), DW'(rbusy[k]), DW'(exp_rb[k]));
        end
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        ren = '0; iss_en = 0; iss_addr = '0;
    endtask

    // Inputs are set at the falling edge; outputs are compared at the next falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        ren[k] = 1'b1;
        raddr[k*AW +: AW] = a;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset rdata", rdata[DW-1:0], 32'h0);
        chk("reset rbusy", DW'(rbusy), 32'h0);

        // Release mid-cycle with a write pending: that edge must be ignored.
        rst = 1'b1;
        wen0 = 1; waddr0 = 5'd1; wdata0 = 32'hDEAD_BEEF; iss_en = 1; iss_addr = 5'd1;
        step("release edge");
        idle(); set_rd(0, 5'd1);
        step("post-release read");
        chk("release write ignored", rdata[DW-1:0], 32'h0);
        chk("release issue ignored", DW'(rbusy[0]), 32'h0);

        // Basic write then read.
        idle(); wen0 = 1; waddr0 = 5'd5; wdata0 = 32'h1234;
        step("write 5");
        idle(); set_rd(0, 5'd5);
        step("read 5");
        chk("read5 data", rdata[DW-1:0], 32'h0000_1234);

        // Both write ports to the same entry: port 1 wins.
        idle(); wen0 = 1; wen1 = 1; waddr0 = 5'd7; waddr1 = 5'd7; wdata0 = 32'hAAAA; wdata1 = 32'h5555;
        step("dual write 7");
        idle(); set_rd(1, 5'd7);
        step("read 7");
        chk("port1 priority", rdata[DW +: DW], 32'h5555);

        // Entry 0 ignores writes and issues.
        idle(); wen0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; iss_en = 1; iss_addr = 5'd0;
        step("write/iss 0");
        idle(); set_rd(0, 5'd0); set_rd(1, 5'd0);
        step("read 0");
        chk("r0 data", rdata[DW-1:0], 32'h0);
        chk("r0 busy", DW'(rbusy), 32'h0);

        // Scoreboard set / clear / issue-wins.
        idle(); iss_en = 1; iss_addr = 5'd9;
        step("iss 9");
        idle(); set_rd(0, 5'd9);
        step("read 9 busy");
        chk("busy after issue", DW'(rbusy[0]), 32'h1);
        idle(); wen1 = 1; waddr1 = 5'd9; wdata1 = 32'h77;
        step("write 9");
        idle(); set_rd(0, 5'd9);
        step("read 9 clear");
        chk("busy cleared", DW'(rbusy[0]), 32'h0);
        chk("data 9", rdata[DW-1:0], 32'h77);
        idle(); iss_en = 1; iss_addr = 5'd9; wen0 = 1; waddr0 = 5'd9; wdata0 = 32'h88;
        step("iss+write 9");
        idle(); set_rd(0, 5'd9);
        step("read 9 again");
        chk("issue wins", DW'(rbusy[0]), 32'h1);
        chk("data 9 new", rdata[DW-1:0], 32'h88);

        // Same-edge write/read collision.
        idle(); wen0 = 1; waddr0 = 5'd3; wdata0 = 32'h10; iss_en = 1; iss_addr = 5'd3;
        step("write 3");
        idle(); wen0 = 1; waddr0 = 5'd3; wdata0 = 32'h20; set_rd(0, 5'd3);
        step("collide 3");
`ifdef YSYX_24120013_RF_BYPASS_EN
        chk("collide data", rdata[DW-1:0], 32'h20);
        chk("collide busy", DW'(rbusy[0]), 32'h0);
`else
        chk("collide data", rdata[DW-1:0], 32'h10);
        chk("collide busy", DW'(rbusy[0]), 32'h1);
`endif
        // Disabled port holds its last value even if raddr moves.
        idle(); raddr[0 +: AW] = 5'd5;
        step("hold");
`ifdef YSYX_24120013_RF_BYPASS_EN
        chk("hold data", rdata[DW-1:0], 32'h20);
`else
        chk("hold data", rdata[DW-1:0], 32'h10);
`endif
        idle(); set_rd(0, 5'd3); set_rd(1, 5'd3);
        step("read 3 after");
        chk("3 final", rdata[DW +: DW], 32'h20);

        // Reset in the middle of activity.
        idle(); wen0 = 1; waddr0 = 5'd1; wdata0 = 32'h11; wen1 = 1; waddr1 = 5'd2; wdata1 = 32'h22;
        step("fill 1,2");
        idle(); wen0 = 1; waddr0 = 5'd3; wdata0 = 32'h33; wen1 = 1; waddr1 = 5'd4; wdata1 = 32'h44;
        iss_en = 1; iss_addr = 5'd2;
        step("fill 3,4 iss 2");
        idle(); set_rd(0, 5'd2); set_rd(1, 5'd4);
        step("read 2,4");
        chk("pre-reset busy2", DW'(rbusy[0]), 32'h1);
        chk("pre-reset data4", rdata[DW +: DW], 32'h44);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async clr rdata", rdata[DW-1:0], 32'h0);
        chk("async clr rdata1", rdata[DW +: DW], 32'h0);
        chk("async clr rbusy", DW'(rbusy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        step("release 2");
        idle(); set_rd(0, 5'd1); set_rd(1, 5'd2);
        step("read 1,2 after rst");
        chk("rst e1", rdata[DW-1:0], 32'h0);
        chk("rst e2", rdata[DW +: DW], 32'h0);
        chk("rst busy2", DW'(rbusy[1]), 32'h0);
        idle(); set_rd(0, 5'd3); set_rd(1, 5'd4);
        step("read 3,4 after rst");
        chk("rst e3", rdata[DW-1:0], 32'h0);
        chk("rst e4", rdata[DW +: DW], 32'h0);

        // Randomized traffic over a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            wen0     = 1'($urandom);
            wen1     = 1'($urandom);
            waddr0   = AW'($urandom_range(0, 7));
            waddr1   = AW'($urandom_range(0, 7));
            wdata0   = $urandom;
            wdata1   = $urandom;
            iss_en   = 1'($urandom);
            iss_addr = AW'($urandom_range(0, 7));
            ren      = NR'($urandom);
            for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
